action_selector: RTL and testbench
==================================

Name: action_selector

Overview:
- Epsilon-greedy action generator directly upstream of the Q-update pipeline; drives its 3-bit action input once per cycle.
- Chooses between a pseudo-random exploratory action (on-chip LFSR) and a greedy action supplied by the policy side.
- Bounds each episode to a fixed number of steps.
- Optionally decays epsilon over time.

Parameters:
- MAX_STEPS, 65536, actions issued per episode (≥1).
- STEP_W, 17, width of step_count; must hold MAX_STEPS.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- EPS_INIT, 8'd51, initial epsilon in 1/256 units (≈0.2).
- EPS_MIN, 8'd3, epsilon floor (decay build only).
- EPS_STEP, 8'd1, epsilon decrement per decay event.
- DECAY_STEPS, 1024, actions between decay events.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  pulse; begins an episode from IDLE or DONE
- greedy_action  in  3  exploit choice, sampled in the same cycle it is used
- action  out  3  action to pipeline, registered
- action_valid  out  1  action holds a fresh episode action this cycle
- explore  out  1  current action came from the LFSR
- step_count  out  STEP_W  actions issued in current episode
- epsilon  out  8  current exploration threshold
- done  out  1  episode complete; held until next start

Behaviour:
- Reset is asynchronous on rst high: state=IDLE, action=0, action_valid=0, explore=0, step_count=0, epsilon=EPS_INIT, done=0, lfsr=LFSR_SEED, decay counter=0. A reset mid-episode aborts it immediately. No partial outputs survive reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start → RUN.
  - RUN: start is ignored.
  - DONE: start → RUN; on that edge step_count is cleared and done is cleared.
- LFSR: 16-bit Galois, right shift. Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). Advances only on RUN edges; it is frozen in IDLE and DONE. It is not reseeded between episodes.
- Each RUN edge uses the pre-advance lfsr value:
  - explore_n = (epsilon==8'hFF) || (lfsr[7:0] < epsilon).
  - action <= explore_n ? lfsr[10:8] : greedy_action.
  - explore <= explore_n; action_valid <= 1; step_count <= step_count+1.
- Latency: start sampled at edge k gives the first valid action after edge k+1. Actions are then issued one per cycle, back-to-back, with no stalls.
- Episode end:
  - The edge that issues action number MAX_STEPS also sets state <= DONE.
  - On the next edge: action_valid <= 0, explore <= 0, done <= 1.
  - action holds its last value; step_count holds MAX_STEPS.
- start coincident with the final RUN edge is ignored. A new episode needs start while in DONE.
- epsilon is never modified in the base build and persists across episodes.

Optional Feature:
- Macro: ACTION_SEL_EPS_DECAY_EN.
- With the macro:
  - A decay counter runs 0..DECAY_STEPS-1 and advances on every RUN edge.
  - It wraps on each decay event and is not cleared between episodes.
  - On each wrap, epsilon <= (epsilon > EPS_MIN+EPS_STEP-1) ? epsilon-EPS_STEP : EPS_MIN, saturating at EPS_MIN.
  - The explore decision on the wrap edge uses the old epsilon.
- Without the macro: no decay counter; epsilon is constant at EPS_INIT. EPS_MIN, EPS_STEP and DECAY_STEPS are unused.

Test Plan:
- EPS_INIT=0, MAX_STEPS=4, greedy_action=3'd5, start pulse → four cycles with action=5, explore=0, action_valid=1; then done=1, action_valid=0, step_count=4.
- EPS_INIT=8'hFF, seed 16'hACE1, start → actions 4, 2, 1 on the first three valid cycles (lfsr 16'hACE1, 16'hE270, 16'h7138), all with explore=1.
- MAX_STEPS=8: assert rst for one cycle, asynchronously and between clock edges, on the 3rd valid action → outputs return to reset values without waiting for a clock edge; a later start restarts with step_count counting from 1 and lfsr starting again at 16'hACE1.
- In DONE, pulse start → step_count cleared, done=0, action_valid=1 after the next edge; lfsr continues from its frozen value, not the seed. A start issued mid-RUN has no effect on step_count.
- With ACTION_SEL_EPS_DECAY_EN, EPS_INIT=5, EPS_MIN=3, EPS_STEP=1, DECAY_STEPS=2, MAX_STEPS=10 → epsilon 5→4 after the 2nd action, 3 after the 4th, and stays at 3.
- Without the macro, same run → epsilon stays 5 throughout.

Source files
------------

// File: rtl/action_selector.sv
// Epsilon-greedy action generator feeding the Q-update pipeline, one action per cycle per episode.
// Define ACTION_SEL_EPS_DECAY_EN to make epsilon decay towards EPS_MIN every DECAY_STEPS actions.
module action_selector #(
    parameter int          MAX_STEPS   = 65536,
    parameter int          STEP_W      = 17,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [7:0]  EPS_INIT    = 8'd51,
    parameter logic [7:0]  EPS_MIN     = 8'd3,
    parameter logic [7:0]  EPS_STEP    = 8'd1,
    parameter int          DECAY_STEPS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        greedy_action,
    output logic [2:0]        action,
    output logic              action_valid,
    output logic              explore,
    output logic [STEP_W-1:0] step_count,
    output logic [7:0]        epsilon,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic        explore_n;
    logic        last_step;

    // The explore decision always uses the pre-advance LFSR value; epsilon of 0xFF forces exploration.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        explore_n = (epsilon == 8'hFF) || (lfsr[7:0] < epsilon);
        last_step = (step_count == STEP_W'(MAX_STEPS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            action       <= 3'd0;
            action_valid <= 1'b0;
            explore      <= 1'b0;
            step_count   <= '0;
            done         <= 1'b0;
            lfsr         <= LFSR_SEED;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        step_count <= '0;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    action       <= explore_n ? lfsr[10:8] : greedy_action;
                    explore      <= explore_n;
                    action_valid <= 1'b1;
                    step_count   <= step_count + STEP_W'(1);
                    lfsr         <= lfsr_next;
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // action and the LFSR stay frozen so a new episode continues the random sequence.
                    action_valid <= 1'b0;
                    explore      <= 1'b0;
                    if (start) begin
                        state      <= RUN;
                        step_count <= '0;
                        done       <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ACTION_SEL_EPS_DECAY_EN
    localparam int DEC_W = (DECAY_STEPS > 1) ? $clog2(DECAY_STEPS) : 1;

    logic [DEC_W-1:0] decay_count;
    logic             decay_wrap;
    logic [7:0]       eps_decayed;

    // Compare in 9 bits so EPS_MIN+EPS_STEP cannot overflow near the top of the range.
    always_comb begin
        decay_wrap = (decay_count == DEC_W'(DECAY_STEPS - 1));
        if ({1'b0, epsilon} > ({1'b0, EPS_MIN} + {1'b0, EPS_STEP} - 9'd1)) begin
            eps_decayed = epsilon - EPS_STEP;
        end else begin
            eps_decayed = EPS_MIN;
        end
    end

    // The decay counter spans episodes; it only pauses outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epsilon     <= EPS_INIT;
            decay_count <= '0;
        end else if (state == RUN) begin
            if (decay_wrap) begin
                decay_count <= '0;
                epsilon     <= eps_decayed;
            end else begin
                decay_count <= decay_count + DEC_W'(1);
            end
        end
    end
`else
    assign epsilon = EPS_INIT;
`endif

endmodule

// File: tb/tb_action_selector.sv
// Directed self-checking bench for action_selector using four differently configured instances.
module tb_action_selector;

    logic        clk;
    logic        rst_main;
    logic        rst_b;

    logic        start_a, start_b, start_c, start_d;
    logic [2:0]  greedy_a, greedy_b, greedy_c, greedy_d;
    logic [2:0]  action_a, action_b, action_c, action_d;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic        explore_a, explore_b, explore_c, explore_d;
    logic [16:0] step_a, step_b, step_c, step_d;
    logic [7:0]  eps_a, eps_b, eps_c, eps_d;
    logic        done_a, done_b, done_c, done_d;

    int total_checks = 0;
    int bad_checks   = 0;

    // Hand-derived from the Galois LFSR starting at 16'hACE1 (lfsr[10:8] per step).
    logic [2:0] b_acts [8] = '{3'd4, 3'd2, 3'd1, 3'd0, 3'd4, 3'd6, 3'd3, 3'd5};
    logic [2:0] d_acts [3] = '{3'd7, 3'd2, 3'd1};
    logic       d_expl [3] = '{1'b0, 1'b1, 1'b1};
`ifdef ACTION_SEL_EPS_DECAY_EN
    logic [7:0] c_eps [10] = '{8'd5, 8'd4, 8'd4, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
`else
    logic [7:0] c_eps [10] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
`endif

    action_selector #(.MAX_STEPS(4), .EPS_INIT(8'd0)) dut_a (
        .clk(clk), .rst(rst_main), .start(start_a), .greedy_action(greedy_a),
        .action(action_a), .action_valid(valid_a), .explore(explore_a),
        .step_count(step_a), .epsilon(eps_a), .done(done_a)
    );

    action_selector #(.MAX_STEPS(8), .EPS_INIT(8'hFF)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .greedy_action(greedy_b),
        .action(action_b), .action_valid(valid_b), .explore(explore_b),
        .step_count(step_b), .epsilon(eps_b), .done(done_b)
    );

    action_selector #(.MAX_STEPS(10), .EPS_INIT(8'd5), .EPS_MIN(8'd3), .EPS_STEP(8'd1),
                      .DECAY_STEPS(2)) dut_c (
        .clk(clk), .rst(rst_main), .start(start_c), .greedy_action(greedy_c),
        .action(action_c), .action_valid(valid_c), .explore(explore_c),
        .step_count(step_c), .epsilon(eps_c), .done(done_c)
    );

    // Epsilon equals the seed's low byte, so the first decision sits exactly on the strict-less boundary.
    action_selector #(.MAX_STEPS(3), .EPS_INIT(8'hE1)) dut_d (
        .clk(clk), .rst(rst_main), .start(start_d), .greedy_action(greedy_d),
        .action(action_d), .action_valid(valid_d), .explore(explore_d),
        .step_count(step_d), .epsilon(eps_d), .done(done_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the start pulse is seen by exactly one rising edge.
    task automatic applyStimulus(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
    endtask

    initial begin
        rst_main = 1'b1;
        rst_b    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        start_d  = 1'b0;
        greedy_a = 3'd5;
        greedy_b = 3'd0;
        greedy_c = 3'd0;
        greedy_d = 3'd7;
        repeat (2) @(negedge clk);

        checkOutput("rst_action", 32'(action_a), 32'd0);
        checkOutput("rst_valid", 32'(valid_a), 32'd0);
        checkOutput("rst_explore", 32'(explore_a), 32'd0);
        checkOutput("rst_step", 32'(step_a), 32'd0);
        checkOutput("rst_done", 32'(done_a), 32'd0);
        checkOutput("rst_eps_b", 32'(eps_b), 32'hFF);
        checkOutput("rst_eps_c", 32'(eps_c), 32'd5);

        rst_main = 1'b0;
        rst_b    = 1'b0;
        @(negedge clk);

        // Pure exploitation episode of four actions.
        applyStimulus(0);
        checkOutput("a_latency", 32'(valid_a), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("a_act%0d", i), 32'(action_a), 32'd5);
            checkOutput($sformatf("a_expl%0d", i), 32'(explore_a), 32'd0);
            checkOutput($sformatf("a_valid%0d", i), 32'(valid_a), 32'd1);
            checkOutput($sformatf("a_step%0d", i), 32'(step_a), 32'(i));
            checkOutput($sformatf("a_done%0d", i), 32'(done_a), 32'd0);
        end
        @(negedge clk);
        checkOutput("a_end_done", 32'(done_a), 32'd1);
        checkOutput("a_end_valid", 32'(valid_a), 32'd0);
        checkOutput("a_end_step", 32'(step_a), 32'd4);
        checkOutput("a_end_action", 32'(action_a), 32'd5);
        @(negedge clk);
        checkOutput("a_hold_done", 32'(done_a), 32'd1);

        // Restart from DONE with a different greedy choice, then poke start mid-run.
        greedy_a = 3'd2;
        applyStimulus(0);
        checkOutput("a_restart_step", 32'(step_a), 32'd0);
        checkOutput("a_restart_done", 32'(done_a), 32'd0);
        checkOutput("a_restart_valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        checkOutput("a_r_act1", 32'(action_a), 32'd2);
        checkOutput("a_r_step1", 32'(step_a), 32'd1);
        checkOutput("a_r_valid1", 32'(valid_a), 32'd1);
        applyStimulus(0);
        checkOutput("a_midstart_step2", 32'(step_a), 32'd2);
        @(negedge clk);
        checkOutput("a_midstart_step3", 32'(step_a), 32'd3);
        @(negedge clk);
        checkOutput("a_midstart_step4", 32'(step_a), 32'd4);
        @(negedge clk);
        checkOutput("a_r_end_done", 32'(done_a), 32'd1);
        checkOutput("a_r_end_step", 32'(step_a), 32'd4);

        // Strict less-than boundary: lfsr low byte E1 equals epsilon, so the first action is greedy.
        applyStimulus(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("d_act%0d", i + 1), 32'(action_d), 32'(d_acts[i]));
            checkOutput($sformatf("d_expl%0d", i + 1), 32'(explore_d), 32'(d_expl[i]));
        end

        // Always-explore episode, aborted by an asynchronous reset on the third action.
        applyStimulus(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("b_act%0d", i + 1), 32'(action_b), 32'(b_acts[i]));
            checkOutput($sformatf("b_expl%0d", i + 1), 32'(explore_b), 32'd1);
        end
        #2 rst_b = 1'b1;
        #1;
        checkOutput("b_async_valid", 32'(valid_b), 32'd0);
        checkOutput("b_async_action", 32'(action_b), 32'd0);
        checkOutput("b_async_explore", 32'(explore_b), 32'd0);
        checkOutput("b_async_step", 32'(step_b), 32'd0);
        checkOutput("b_async_done", 32'(done_b), 32'd0);
        #1 rst_b = 1'b0;
        @(negedge clk);

        applyStimulus(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("b2_act%0d", i + 1), 32'(action_b), 32'(b_acts[i]));
            checkOutput($sformatf("b2_expl%0d", i + 1), 32'(explore_b), 32'd1);
            checkOutput($sformatf("b2_step%0d", i + 1), 32'(step_b), 32'(i + 1));
        end
        @(negedge clk);
        checkOutput("b2_done", 32'(done_b), 32'd1);
        checkOutput("b2_end_step", 32'(step_b), 32'd8);
        checkOutput("b2_end_explore", 32'(explore_b), 32'd0);

        // Second episode continues from the frozen LFSR value C2C4, not the seed.
        applyStimulus(1);
        @(negedge clk);
        checkOutput("b3_act1", 32'(action_b), 32'd2);
        checkOutput("b3_step1", 32'(step_b), 32'd1);
        @(negedge clk);
        checkOutput("b3_act2", 32'(action_b), 32'd1);
        checkOutput("b3_step2", 32'(step_b), 32'd2);

        // Epsilon trajectory over a ten-step episode.
        applyStimulus(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("c_eps%0d", i + 1), 32'(eps_c), 32'(c_eps[i]));
            checkOutput($sformatf("c_expl%0d", i + 1), 32'(explore_c), 32'd0);
            checkOutput($sformatf("c_act%0d", i + 1), 32'(action_c), 32'd0);
        end
        @(negedge clk);
        checkOutput("c_done", 32'(done_c), 32'd1);
        checkOutput("c_end_eps", 32'(eps_c), 32'(c_eps[9]));

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
